fbuf_write_scheduler: RTL and testbench
=======================================

// Module: fbuf_write_scheduler
// PURPOSE
//  Sole owner of the framebuffer BRAM write port. Shares that port between two requesters: single-pixel
//  writes from the AXI-lite GPU register decode, and an internal rectangle-fill engine (clear screen, solid
//  boxes). Converts (x,y) coordinates to linear addresses, clips to the frame and stalls while the BRAM resets.
// PARAMETERS
//  FRAME_WIDTH      640  pixels per line; linear address = y*FRAME_WIDTH + x
//  FRAME_HEIGHT     480  lines per frame
//  COORD_WIDTH      12   width of every x/y/w/h field
//  FBUF_ADDR_WIDTH  19   BRAM address width
//  FBUF_DATA_WIDTH  8    pixel width
// PORTS
//  clk            in   1    single clock for all logic
//  rst            in   1    synchronous, active-high reset
//  fbuf_rst_busy  in   1    BRAM reset in progress; no writes may issue
//  px_valid       in   1    pixel-write request
//  px_ready       out  1    pixel request accepted this cycle (handshake = px_valid & px_ready)
//  px_x, px_y     in   CW   pixel coordinates
//  px_color       in   DW   pixel value
//  fill_start     in   1    one-cycle pulse to start a fill; sampled only in IDLE
//  fill_x, fill_y in   CW   rectangle top-left corner
//  fill_w, fill_h in   CW   rectangle size in pixels
//  fill_color     in   DW   fill value
//  fill_busy      out  1    fill in progress
//  fill_done      out  1    one-cycle completion pulse
//  fbuf_en_wr     out  1    BRAM enable
//  fbuf_wrea      out  1    BRAM write enable (always equal to fbuf_en_wr)
//  fbuf_addr      out  AW   BRAM address
//  fbuf_data      out  DW   BRAM data
// BEHAVIOUR
//  Reset: all outputs 0 (px_ready, fill_busy, fill_done, fbuf_*). FSM goes to IDLE; last_px = 0.
//    Reset mid-fill aborts the fill with no fill_done.
//  FSM IDLE -> FILL on fill_start after clipping, if the clipped area is non-empty.
//    Capture is clipped: w' = min(w, FRAME_WIDTH-x), h' = min(h, FRAME_HEIGHT-y).
//    Empty area (w==0, h==0, x>=FRAME_WIDTH or y>=FRAME_HEIGHT): stay IDLE, pulse fill_done next cycle, no writes.
//  FILL walks the rectangle row-major. Address is tracked incrementally:
//    row_base += FRAME_WIDTH per row; addr = row_base + col. No multiplier on this path.
//    FILL -> DONE when the last pixel is granted; DONE -> IDLE after one cycle.
//  fill_busy = (state==FILL) | (state==DONE).
//  fill_done is high in DONE, the same cycle the last write is on fbuf_*.
//  fill_start outside IDLE is ignored.
//  Grant (combinational, one writer per cycle):
//    fbuf_rst_busy=1: no grant; px_ready=0; fill position is held.
//    IDLE or DONE: pixel granted whenever px_valid.
//    FILL with px_valid: alternate. Pixel wins if last_px==0, otherwise fill wins.
//      last_px <= 1 on a pixel grant, 0 on a fill grant.
//    FILL without px_valid: fill is granted every cycle.
//  px_ready = grant to pixel (it may depend on px_valid).
//  Pixel path: addr = px_y*FRAME_WIDTH + px_x, truncated to AW.
//    Out-of-frame (x>=W or y>=H): handshake completes but no write issues.
//  Write outputs are registered: a grant in cycle N puts en/wrea/addr/data on fbuf_* in cycle N+1 for exactly one cycle.
//    With no grant, en=wrea=0 and addr=data=0.
//  Fill latency, no contention: fill_start at N gives writes in cycles N+2 .. N+1+w'*h', with fill_done in N+1+w'*h'.
// TESTING
//  1. Reset, then px (3,2,0xAB): handshake at N -> N+1 en=wrea=1, addr=1283, data=0xAB; N+2 all 0.
//  2. fill (10,5,w=3,h=2,0x55): 6 writes, addr 3210,3211,3212,3850,3851,3852;
//     fill_done coincides with write 6; fill_busy low afterwards.
//  3. fill (638,479,w=10,h=10): clipped to 2 writes at 307198, 307199.
//     fill w=0: fill_done at N+1, no writes.
//  4. px_valid held high during a 4-pixel fill: grants alternate px,fill,px,fill...
//     Fill finishes in 8 cycles; no cycle has two writers.
//  5. fbuf_rst_busy high 5 cycles mid-fill: fbuf_en_wr=0 and px_ready=0 throughout;
//     fill resumes at the next address with no skip or duplicate.
//  6. px (640,0) and (0,480): px_ready=1, no write.
//     rst asserted mid-fill: next cycle all outputs 0, no fill_done; a new fill_start is accepted.

Source files
------------

// File: rtl/fbuf_write_scheduler.sv
// rtl/fbuf_write_scheduler.sv - framebuffer BRAM write-port arbiter with rectangle-fill engine
//
// Purpose:
//   Owns the framebuffer BRAM write port and shares it between single-pixel
//   writes (px_*) and an internal rectangle-fill engine (fill_*). Coordinates
//   are converted to linear addresses (y*FRAME_WIDTH + x), fills are clipped to
//   the frame, and nothing is written while the BRAM reports fbuf_rst_busy.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fbuf_rst_busy         BRAM reset in progress; blocks all grants
//   px_valid/px_ready     pixel request handshake
//   px_x, px_y, px_color  pixel coordinates and value
//   fill_start            one-cycle start pulse, honoured only in IDLE
//   fill_x/y/w/h/color    rectangle corner, size and value
//   fill_busy, fill_done  fill in progress / one-cycle completion pulse
//   fbuf_en_wr, fbuf_wrea BRAM enable and write enable (identical)
//   fbuf_addr, fbuf_data  BRAM address and data, registered

module fbuf_write_scheduler #(
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int COORD_WIDTH     = 12,
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fbuf_rst_busy,
  input  logic                       px_valid,
  output logic                       px_ready,
  input  logic [COORD_WIDTH-1:0]     px_x,
  input  logic [COORD_WIDTH-1:0]     px_y,
  input  logic [FBUF_DATA_WIDTH-1:0] px_color,
  input  logic                       fill_start,
  input  logic [COORD_WIDTH-1:0]     fill_x,
  input  logic [COORD_WIDTH-1:0]     fill_y,
  input  logic [COORD_WIDTH-1:0]     fill_w,
  input  logic [COORD_WIDTH-1:0]     fill_h,
  input  logic [FBUF_DATA_WIDTH-1:0] fill_color,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);

  localparam int CW = COORD_WIDTH;
  localparam int AW = FBUF_ADDR_WIDTH;
  localparam int DW = FBUF_DATA_WIDTH;

  localparam logic [CW-1:0] FW_C  = CW'(FRAME_WIDTH);
  localparam logic [CW-1:0] FH_C  = CW'(FRAME_HEIGHT);
  localparam logic [AW-1:0] FW_A  = AW'(FRAME_WIDTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic          last_px;   // 1 when the previous grant went to the pixel path
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [CW-1:0] wc;        // clipped width
  logic [CW-1:0] hc;        // clipped height
  logic [AW-1:0] row_base;  // linear address of the current row's first pixel
  logic [DW-1:0] color_r;

  // Fill capture: clipping and start address
  logic [CW-1:0] x_room;
  logic [CW-1:0] y_room;
  logic [CW-1:0] w_clip;
  logic [CW-1:0] h_clip;
  logic          fill_empty;
  logic [AW-1:0] start_base;

  // x_room/y_room are only meaningful when the corner is inside the frame;
  // otherwise fill_empty already suppresses the fill.
  assign x_room     = FW_C - fill_x;
  assign y_room     = FH_C - fill_y;
  assign w_clip     = (fill_w < x_room) ? fill_w : x_room;
  assign h_clip     = (fill_h < y_room) ? fill_h : y_room;
  assign fill_empty = (fill_w == '0) || (fill_h == '0) ||
                      (fill_x >= FW_C) || (fill_y >= FH_C);
  assign start_base = AW'(fill_y) * FW_A + AW'(fill_x);

  // Pixel path
  logic          px_in_frame;
  logic [AW-1:0] px_addr;

  assign px_in_frame = (px_x < FW_C) && (px_y < FH_C);
  assign px_addr     = AW'(px_y) * FW_A + AW'(px_x);

  // Fill walk: incremental address, no multiply per pixel
  logic [AW-1:0] fill_addr;
  logic          last_col;
  logic          last_row;

  assign fill_addr = row_base + AW'(col);
  assign last_col  = (col == wc - ONE_C);
  assign last_row  = (row == hc - ONE_C);

  // Grant: one writer per cycle. During a fill with a pending pixel the two
  // requesters alternate so neither can starve the other.
  logic can_write;
  logic grant_px;
  logic grant_fill;

  assign can_write  = !rst && !fbuf_rst_busy;
  assign grant_px   = can_write && px_valid && ((state != S_FILL) || !last_px);
  assign grant_fill = can_write && (state == S_FILL) && (!px_valid || last_px);

  assign px_ready  = grant_px;
  assign fbuf_wrea = fbuf_en_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_px    <= 1'b0;
      col        <= '0;
      row        <= '0;
      wc         <= '0;
      hc         <= '0;
      row_base   <= '0;
      color_r    <= '0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      fbuf_en_wr <= 1'b0;
      fbuf_addr  <= '0;
      fbuf_data  <= '0;
    end else begin
      fill_done <= 1'b0;

      // Registered write port; idle cycles drive zeros on addr/data.
      if (grant_fill) begin
        fbuf_en_wr <= 1'b1;
        fbuf_addr  <= fill_addr;
        fbuf_data  <= color_r;
      end else if (grant_px && px_in_frame) begin
        fbuf_en_wr <= 1'b1;
        fbuf_addr  <= px_addr;
        fbuf_data  <= px_color;
      end else begin
        fbuf_en_wr <= 1'b0;
        fbuf_addr  <= '0;
        fbuf_data  <= '0;
      end

      if (grant_px) begin
        last_px <= 1'b1;
      end else if (grant_fill) begin
        last_px <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (fill_start) begin
            if (fill_empty) begin
              fill_done <= 1'b1;
            end else begin
              state     <= S_FILL;
              fill_busy <= 1'b1;
              wc        <= w_clip;
              hc        <= h_clip;
              col       <= '0;
              row       <= '0;
              row_base  <= start_base;
              color_r   <= fill_color;
            end
          end
        end

        S_FILL: begin
          // Position only advances on a fill grant, so a BRAM-reset stall
          // or a pixel turn holds it exactly where it is.
          if (grant_fill) begin
            if (last_col) begin
              col      <= '0;
              row_base <= row_base + FW_A;
              if (last_row) begin
                state     <= S_DONE;
                fill_done <= 1'b1;
              end else begin
                row <= row + ONE_C;
              end
            end else begin
              col <= col + ONE_C;
            end
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          fill_busy <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fbuf_write_scheduler.sv
// tb/tb_fbuf_write_scheduler.sv - directed self-checking bench for fbuf_write_scheduler

module tb_fbuf_write_scheduler;

  logic        clk;
  logic        rst;
  logic        fbuf_rst_busy;
  logic        px_valid;
  logic        px_ready;
  logic [11:0] px_x;
  logic [11:0] px_y;
  logic [7:0]  px_color;
  logic        fill_start;
  logic [11:0] fill_x;
  logic [11:0] fill_y;
  logic [11:0] fill_w;
  logic [11:0] fill_h;
  logic [7:0]  fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        fbuf_en_wr;
  logic        fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;

  int n_checks;
  int n_fail;

  fbuf_write_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .fbuf_rst_busy (fbuf_rst_busy),
    .px_valid      (px_valid),
    .px_ready      (px_ready),
    .px_x          (px_x),
    .px_y          (px_y),
    .px_color      (px_color),
    .fill_start    (fill_start),
    .fill_x        (fill_x),
    .fill_y        (fill_y),
    .fill_w        (fill_w),
    .fill_h        (fill_h),
    .fill_color    (fill_color),
    .fill_busy     (fill_busy),
    .fill_done     (fill_done),
    .fbuf_en_wr    (fbuf_en_wr),
    .fbuf_wrea     (fbuf_wrea),
    .fbuf_addr     (fbuf_addr),
    .fbuf_data     (fbuf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_port(input string tag);
    check_eq({tag, "_en"},   32'(fbuf_en_wr), 32'd0);
    check_eq({tag, "_wrea"}, 32'(fbuf_wrea),  32'd0);
    check_eq({tag, "_addr"}, 32'(fbuf_addr),  32'd0);
    check_eq({tag, "_data"}, 32'(fbuf_data),  32'd0);
  endtask

  // Uncontended fill; exp_base/exp_w/exp_h are the hand-clipped rectangle.
  task automatic run_fill(input string tag,
                          input logic [11:0] x, input logic [11:0] y,
                          input logic [11:0] w, input logic [11:0] h,
                          input logic [7:0] color,
                          input int exp_base, input int exp_w, input int exp_h);
    fill_x = x; fill_y = y; fill_w = w; fill_h = h; fill_color = color;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    #1;
    check_eq({tag, "_first_gap_en"}, 32'(fbuf_en_wr), 32'd0);
    check_eq({tag, "_busy"}, 32'(fill_busy), 32'd1);
    for (int r = 0; r < exp_h; r++) begin
      for (int c = 0; c < exp_w; c++) begin
        tick();
        check_eq($sformatf("%s_en_%0d_%0d", tag, r, c), 32'(fbuf_en_wr), 32'd1);
        check_eq($sformatf("%s_wrea_%0d_%0d", tag, r, c), 32'(fbuf_wrea), 32'd1);
        check_eq($sformatf("%s_addr_%0d_%0d", tag, r, c), 32'(fbuf_addr),
                 32'(exp_base + r * 640 + c));
        check_eq($sformatf("%s_data_%0d_%0d", tag, r, c), 32'(fbuf_data), 32'(color));
        check_eq($sformatf("%s_done_%0d_%0d", tag, r, c), 32'(fill_done),
                 32'((r == exp_h - 1) && (c == exp_w - 1)));
      end
    end
    tick();
    check_eq({tag, "_busy_after"}, 32'(fill_busy), 32'd0);
    check_eq({tag, "_done_after"}, 32'(fill_done), 32'd0);
    check_idle_port({tag, "_after"});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; fbuf_rst_busy = 1'b0;
    px_valid = 1'b1; px_x = '0; px_y = '0; px_color = '0;
    fill_start = 1'b0; fill_x = '0; fill_y = '0; fill_w = '0; fill_h = '0; fill_color = '0;

    // Reset state
    tick();
    tick();
    check_idle_port("reset");
    check_eq("reset_busy",  32'(fill_busy), 32'd0);
    check_eq("reset_done",  32'(fill_done), 32'd0);
    check_eq("reset_ready", 32'(px_ready),  32'd0);
    rst = 1'b0;
    px_valid = 1'b0;

    // 1. Single pixel (3,2) -> 2*640+3 = 1283
    tick();
    px_x = 12'd3; px_y = 12'd2; px_color = 8'hAB; px_valid = 1'b1;
    #1;
    check_eq("px_ready", 32'(px_ready), 32'd1);
    tick();
    px_valid = 1'b0;
    check_eq("px_en",   32'(fbuf_en_wr), 32'd1);
    check_eq("px_wrea", 32'(fbuf_wrea),  32'd1);
    check_eq("px_addr", 32'(fbuf_addr),  32'd1283);
    check_eq("px_data", 32'(fbuf_data),  32'hAB);
    tick();
    check_idle_port("px_next");

    // 2. Fill (10,5) 3x2 -> 3210..3212, 3850..3852
    run_fill("fill2", 12'd10, 12'd5, 12'd3, 12'd2, 8'h55, 3210, 3, 2);

    // 3. Clipped fill (638,479) 10x10 -> 2x1 at 307198
    run_fill("clip", 12'd638, 12'd479, 12'd10, 12'd10, 8'h77, 307198, 2, 1);

    // 3b. Empty fill (w=0): done next cycle, no write
    fill_x = 12'd4; fill_y = 12'd4; fill_w = 12'd0; fill_h = 12'd3; fill_color = 8'h99;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    check_eq("empty_done", 32'(fill_done),  32'd1);
    check_eq("empty_en",   32'(fbuf_en_wr), 32'd0);
    check_eq("empty_busy", 32'(fill_busy),  32'd0);
    tick();
    check_eq("empty_done_after", 32'(fill_done), 32'd0);
    check_idle_port("empty_after");

    // 4. Contention: 4-pixel fill at (0,0) with pixel (1,1)=641 pending
    fill_x = 12'd0; fill_y = 12'd0; fill_w = 12'd4; fill_h = 12'd1; fill_color = 8'h11;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    px_x = 12'd1; px_y = 12'd1; px_color = 8'h22; px_valid = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("alt_ready_%0d", k), 32'(px_ready), 32'(k % 2 == 0));
      tick();
      check_eq($sformatf("alt_en_%0d", k), 32'(fbuf_en_wr), 32'd1);
      if (k % 2 == 0) begin
        check_eq($sformatf("alt_px_addr_%0d", k), 32'(fbuf_addr), 32'd641);
        check_eq($sformatf("alt_px_data_%0d", k), 32'(fbuf_data), 32'h22);
      end else begin
        check_eq($sformatf("alt_fill_addr_%0d", k), 32'(fbuf_addr), 32'(k / 2));
        check_eq($sformatf("alt_fill_data_%0d", k), 32'(fbuf_data), 32'h11);
      end
      check_eq($sformatf("alt_done_%0d", k), 32'(fill_done), 32'(k == 7));
    end
    px_valid = 1'b0;
    tick();
    check_eq("alt_busy_after", 32'(fill_busy), 32'd0);
    check_idle_port("alt_after");

    // 5. BRAM reset stall mid-fill: (0,10) 3x1 -> 6400, stall, 6401, 6402
    fill_x = 12'd0; fill_y = 12'd10; fill_w = 12'd3; fill_h = 12'd1; fill_color = 8'h33;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    check_eq("stall_w0_addr", 32'(fbuf_addr), 32'd6400);
    fbuf_rst_busy = 1'b1;
    px_x = 12'd5; px_y = 12'd5; px_color = 8'h44; px_valid = 1'b1;
    #1;
    check_eq("stall_ready_pre", 32'(px_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("stall_en_%0d", k),    32'(fbuf_en_wr), 32'd0);
      check_eq($sformatf("stall_ready_%0d", k), 32'(px_ready),   32'd0);
      check_eq($sformatf("stall_busy_%0d", k),  32'(fill_busy),  32'd1);
    end
    fbuf_rst_busy = 1'b0;
    px_valid = 1'b0;
    tick();
    check_eq("stall_w1_en",   32'(fbuf_en_wr), 32'd1);
    check_eq("stall_w1_addr", 32'(fbuf_addr),  32'd6401);
    check_eq("stall_w1_done", 32'(fill_done),  32'd0);
    tick();
    check_eq("stall_w2_en",   32'(fbuf_en_wr), 32'd1);
    check_eq("stall_w2_addr", 32'(fbuf_addr),  32'd6402);
    check_eq("stall_w2_data", 32'(fbuf_data),  32'h33);
    check_eq("stall_w2_done", 32'(fill_done),  32'd1);
    tick();
    check_idle_port("stall_after");

    // 6. Out-of-frame pixels: handshake, no write
    px_x = 12'd640; px_y = 12'd0; px_color = 8'hEE; px_valid = 1'b1;
    #1;
    check_eq("oof_x_ready", 32'(px_ready), 32'd1);
    tick();
    check_idle_port("oof_x");
    px_x = 12'd0; px_y = 12'd480;
    #1;
    check_eq("oof_y_ready", 32'(px_ready), 32'd1);
    tick();
    px_valid = 1'b0;
    check_idle_port("oof_y");

    // 6b. Reset mid-fill aborts without fill_done
    fill_x = 12'd0; fill_y = 12'd0; fill_w = 12'd10; fill_h = 12'd10; fill_color = 8'h66;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    tick();
    check_eq("abort_pre_en", 32'(fbuf_en_wr), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_port("abort");
    check_eq("abort_busy", 32'(fill_busy), 32'd0);
    check_eq("abort_done", 32'(fill_done), 32'd0);
    tick();
    check_eq("abort_done_next", 32'(fill_done), 32'd0);
    check_idle_port("abort_next");

    // New fill after abort: (20,1) 2x1 -> 660, 661
    run_fill("refill", 12'd20, 12'd1, 12'd2, 12'd1, 8'h5A, 660, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
